// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and step/counter sizing helpers for serial_adder
package serial_adder_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic int steps(input int width, input int chunk);
        return width / chunk;
    endfunction
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/serial_adder_chunk_adder.sv
// chunk_adder: W-bit ripple adder of full_adder cells; ports i_a/i_b/i_cin in, o_sum/o_cout/o_cmsb (carry into MSB) out
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);
    logic [W:0] w_c;
    assign w_c[0] = i_cin;
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .i_a   (i_a[i]),
            .i_b   (i_b[i]),
            .i_cin (w_c[i]),
            .o_sum (o_sum[i]),
            .o_cout(w_c[i+1])
        );
    end
    assign o_cout = w_c[W];
    assign o_cmsb = w_c[W-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial WIDTH-bit adder, CHUNK bits/cycle; i_clk,i_rst,i_start,i_a,i_b,i_cin[,i_sub if SERIAL_ADDER_SUB_EN] in, o_busy,o_done,o_sum,o_cout,o_overflow out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);
    localparam int STEPS = steps(WIDTH, CHUNK);
    localparam int CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    chunk_adder #(.W(CHUNK)) u_chunk (
        .i_a   (r_a[CHUNK-1:0]),
        .i_b   (r_b[CHUNK-1:0]),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_cout(w_cout),
        .o_cmsb(w_cmsb)
    );
    // Result including the chunk being added this cycle, so the last step can load o_sum directly
    always_comb begin
        w_res = r_res;
        w_res[int'(r_cnt)*CHUNK +: CHUNK] = w_sum;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_sum      <= '0;
            o_cout     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_a     <= i_a;
`ifdef SERIAL_ADDER_SUB_EN
                    // Subtract as A + ~B + ~Cin; inverting at capture keeps the RUN path add-only
                    r_b     <= i_sub ? ~i_b : i_b;
                    r_carry <= i_cin ^ i_sub;
`else
                    r_b     <= i_b;
                    r_carry <= i_cin;
`endif
                    r_cnt   <= '0;
                    r_state <= RUN;
                    o_busy  <= 1'b1;
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_cout;
                    r_res   <= w_res;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state    <= IDLE;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_sum      <= w_res;
                        o_cout     <= w_cout;
                        o_overflow <= w_cmsb ^ w_cout;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder (WIDTH=16, CHUNK=4 and CHUNK=16)
module tb_serial_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic        s16 = 0;
    logic [15:0] a = 0;
    logic [15:0] b = 0;
    logic        cin = 0;
    logic        sub = 0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub(sub),
`endif
        .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout), .o_overflow(ovf)
    );

    serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(s16), .i_a(a), .i_b(b), .i_cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub(sub),
`endif
        .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_cout(cout16), .o_overflow(ovf16)
    );

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        exp_t        e;
        logic [15:0] yy;
        logic        cc;
        logic [16:0] r;
        yy = s ? ~y : y;
        cc = s ? ~c : c;
        r = {1'b0, x} + {1'b0, yy} + {16'b0, cc};
        e.sum = r[15:0];
        e.cout = r[16];
        e.ovf = (x[15] == yy[15]) && (r[15] != x[15]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle; expectation is queued only if the DUT can accept it
    task automatic drive_start(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        start = 1; a = x; b = y; cin = c; sub = s;
        if (!busy) q.push_back(model(x, y, c, s));
        @(negedge clk);
        start = 0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    // Called on the first cycle after the capture edge; exp_lat<=0 skips latency/busy checks
    task automatic wait_done(input string tag, input int exp_lat);
        int   n = 1;
        int   nb = 0;
        exp_t e;
        while (!done && n < 40) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (done) begin
            if (exp_lat > 0) begin
                check({tag, "_latency"}, n, exp_lat);
                check({tag, "_busy_cycles"}, nb, exp_lat - 1);
            end
            check({tag, "_sb_nonempty"}, 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({tag, "_sum"}, 32'(sum), 32'(e.sum));
                check({tag, "_cout"}, 32'(cout), 32'(e.cout));
                check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            end
        end
    endtask

    initial begin
        int n;
        int dones;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 0;
        @(negedge clk);

        drive_start(16'h1234, 16'h4321, 0, 0);
        wait_done("basic", 5);
        check("basic_sum_lit", 32'(sum), 32'h5555);
        @(negedge clk);
        check("done_single_pulse", 32'(done), 0);
        check("sum_held", 32'(sum), 32'h5555);

        drive_start(16'hFFFF, 16'h0001, 0, 0);
        wait_done("wrap", 5);
        check("wrap_cout_lit", 32'(cout), 1);

        drive_start(16'h7FFF, 16'h0000, 1, 0);
        wait_done("cin_msb", 5);
        check("cin_msb_ovf_lit", 32'(ovf), 1);

        drive_start(16'h0001, 16'h0001, 0, 0);
        drive_start(16'hAAAA, 16'h1111, 0, 0);
        wait_done("ignore", 0);
        check("ignore_sum_lit", 32'(sum), 32'h0002);
        drive_start(16'h00FF, 16'h0001, 0, 0);
        wait_done("back2back", 5);
        check("back2back_sum_lit", 32'(sum), 32'h0100);

        drive_start(16'h1234, 16'h1111, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        q.delete();
        check("abort_busy", 32'(busy), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        check("abort_ovf", 32'(ovf), 0);
        dones = 0;
        repeat (6) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);

        rst = 1; start = 1; a = 16'h0005; b = 16'h0005;
        @(negedge clk);
        rst = 0; start = 0;
        check("rst_prio_busy", 32'(busy), 0);
        @(negedge clk);
        check("rst_prio_idle", 32'(busy), 0);

        drive_start(16'h0003, 16'h0004, 0, 0);
        wait_done("after_abort", 5);
        check("after_abort_sum_lit", 32'(sum), 32'h0007);

`ifdef SERIAL_ADDER_SUB_EN
        drive_start(16'h0005, 16'h0007, 0, 1);
        wait_done("sub", 5);
        check("sub_sum_lit", 32'(sum), 32'hFFFE);
        check("sub_cout_lit", 32'(cout), 0);
        drive_start(16'h8000, 16'h0001, 0, 1);
        wait_done("sub_ovf", 5);
        check("sub_ovf_lit", 32'(ovf), 1);
`endif

        for (int i = 0; i < 6; i++) begin
            drive_start(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            wait_done("rand", 5);
        end

        s16 = 1; a = 16'h1234; b = 16'h4321; cin = 0; sub = 0;
        @(negedge clk);
        s16 = 0;
        n = 1;
        while (!done16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("c16_latency", n, 2);
        check("c16_sum", 32'(sum16), 32'h5555);
        check("c16_cout", 32'(cout16), 0);
        check("c16_ovf", 32'(ovf16), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
